// File: rtl/ram_port_arbiter.sv
// Two-port round-robin front end for one single-port RAM, with a zero-fill walk after reset
// and a latency-matched tag pipe that steers read data back to the requesting port.
module ram_port_arbiter #(
    parameter int ADDRWIDTH      = 8,
    parameter int DATAWIDTH      = 16,
    parameter int RD_LATENCY     = 1,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 req_a,
    input  logic                 wr_a,
    input  logic [ADDRWIDTH-1:0] addr_a,
    input  logic [DATAWIDTH-1:0] wdata_a,
    output logic                 gnt_a,
    output logic                 rvalid_a,
    output logic [DATAWIDTH-1:0] rdata_a,
    input  logic                 req_b,
    input  logic                 wr_b,
    input  logic [ADDRWIDTH-1:0] addr_b,
    input  logic [DATAWIDTH-1:0] wdata_b,
    output logic                 gnt_b,
    output logic                 rvalid_b,
    output logic [DATAWIDTH-1:0] rdata_b,
    output logic                 ready,
    output logic                 mem_wr,
    output logic [ADDRWIDTH-1:0] mem_address,
    output logic [DATAWIDTH-1:0] mem_write_data,
    input  logic [DATAWIDTH-1:0] mem_read_data,
    output logic                 state_dbg
);

    typedef enum logic {ST_CLEAR = 1'b0, ST_RUN = 1'b1} state_t;

    localparam state_t                 RESET_STATE = (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_RUN;
    localparam logic [ADDRWIDTH-1:0]   LAST_ADDR   = '1;

    state_t                 state;
    state_t                 state_next;
    logic [ADDRWIDTH-1:0]   clr_cnt;
    logic                   last_b;
    logic                   run;
    logic                   push;
    logic [RD_LATENCY-1:0]  tag_valid;
    logic [RD_LATENCY-1:0]  tag_port;

    // Handshake: a request (req_x with stable wr/addr/wdata) is accepted in the cycle its
    // gnt_x is high; the requester keeps req_x up until then and may drop or reissue after.
    assign run   = (state == ST_RUN);
    assign gnt_a = run && req_a && (!req_b || last_b);
    assign gnt_b = run && req_b && !gnt_a;
    assign push  = (gnt_a && !wr_a) || (gnt_b && !wr_b);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= RESET_STATE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        if (state == ST_CLEAR && clr_cnt == LAST_ADDR) begin
            state_next = ST_RUN;
        end
    end

    always_comb begin
        ready          = 1'b0;
        mem_wr         = 1'b0;
        mem_address    = '0;
        mem_write_data = '0;
        case (state)
            ST_CLEAR: begin
                mem_wr      = 1'b1;
                mem_address = clr_cnt;
            end
            ST_RUN: begin
                ready = 1'b1;
                if (gnt_a) begin
                    mem_wr         = wr_a;
                    mem_address    = addr_a;
                    mem_write_data = wdata_a;
                end else if (gnt_b) begin
                    mem_wr         = wr_b;
                    mem_address    = addr_b;
                    mem_write_data = wdata_b;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clr_cnt <= '0;
        end else if (state == ST_CLEAR) begin
            clr_cnt <= clr_cnt + 1'b1;
        end
    end

    // last_b starts at 1 so the first tie after reset goes to port A.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_b <= 1'b1;
        end else if (gnt_a) begin
            last_b <= 1'b0;
        end else if (gnt_b) begin
            last_b <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tag_valid <= '0;
            tag_port  <= '0;
        end else begin
            tag_valid[0] <= push;
            tag_port[0]  <= gnt_b;
            for (int i = 1; i < RD_LATENCY; i++) begin
                tag_valid[i] <= tag_valid[i-1];
                tag_port[i]  <= tag_port[i-1];
            end
        end
    end

    assign rvalid_a  = tag_valid[RD_LATENCY-1] && !tag_port[RD_LATENCY-1];
    assign rvalid_b  = tag_valid[RD_LATENCY-1] &&  tag_port[RD_LATENCY-1];
    assign rdata_a   = mem_read_data;
    assign rdata_b   = mem_read_data;
    assign state_dbg = state;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed bench for ram_port_arbiter (16-word RAM, 3-cycle read latency) with a behavioural RAM.
module tb_ram_port_arbiter;

    localparam int AW = 4;
    localparam int DW = 16;
    localparam int RL = 3;

    logic          clk;
    logic          rst_n;
    logic          req_a, wr_a, req_b, wr_b;
    logic [AW-1:0] addr_a, addr_b;
    logic [DW-1:0] wdata_a, wdata_b;
    logic          gnt_a, gnt_b, rvalid_a, rvalid_b;
    logic [DW-1:0] rdata_a, rdata_b;
    logic          ready, mem_wr, state_dbg;
    logic [AW-1:0] mem_address;
    logic [DW-1:0] mem_write_data, mem_read_data;

    int checks = 0;
    int errors = 0;

    ram_port_arbiter #(
        .ADDRWIDTH(AW), .DATAWIDTH(DW), .RD_LATENCY(RL), .CLEAR_ON_RESET(1)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .req_a(req_a), .wr_a(wr_a), .addr_a(addr_a), .wdata_a(wdata_a),
        .gnt_a(gnt_a), .rvalid_a(rvalid_a), .rdata_a(rdata_a),
        .req_b(req_b), .wr_b(wr_b), .addr_b(addr_b), .wdata_b(wdata_b),
        .gnt_b(gnt_b), .rvalid_b(rvalid_b), .rdata_b(rdata_b),
        .ready(ready), .mem_wr(mem_wr), .mem_address(mem_address),
        .mem_write_data(mem_write_data), .mem_read_data(mem_read_data),
        .state_dbg(state_dbg)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // behavioural single-port RAM with RL-cycle registered read
    logic [DW-1:0] mem [16];
    logic [DW-1:0] rd_pipe [RL];
    always @(posedge clk) begin
        if (mem_wr) mem[mem_address] <= mem_write_data;
        rd_pipe[0] <= mem[mem_address];
        for (int i = 1; i < RL; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
    assign mem_read_data = rd_pipe[RL-1];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_a(input logic req, input logic wr, input logic [AW-1:0] addr, input logic [DW-1:0] wd);
        req_a = req; wr_a = wr; addr_a = addr; wdata_a = wd;
    endtask

    task automatic drive_b(input logic req, input logic wr, input logic [AW-1:0] addr, input logic [DW-1:0] wd);
        req_b = req; wr_b = wr; addr_b = addr; wdata_b = wd;
    endtask

    logic [DW-1:0] exp_rd [3];
    logic [AW-1:0] rd_addr [3];
    logic          exp_ga, exp_gb, exp_va, exp_vb;

    initial begin
        rst_n = 1'b0;
        // requests raised during reset/clear must wait, not be dropped
        drive_a(1'b1, 1'b1, 4'h1, 16'h1111);
        drive_b(1'b1, 1'b1, 4'h2, 16'h2222);

        cycle();
        #1;
        check("rst_ready", ready, 0);
        check("rst_state", state_dbg, 0);
        check("rst_gnt_a", gnt_a, 0);
        check("rst_gnt_b", gnt_b, 0);
        check("rst_rvalid", {rvalid_a, rvalid_b}, 0);
        rst_n = 1'b1;

        // zero-fill walk: 16 cycles, addresses 0..15
        for (int i = 0; i < 16; i++) begin
            #1;
            check("clr_wr", mem_wr, 1);
            check("clr_addr", mem_address, i);
            check("clr_data", mem_write_data, 0);
            check("clr_ready", ready, 0);
            check("clr_gnt", {gnt_a, gnt_b}, 0);
            cycle();
        end

        // first cycle of RUN: tie goes to A
        #1;
        check("run_ready", ready, 1);
        check("run_state", state_dbg, 1);
        check("tie1_gnt_a", gnt_a, 1);
        check("tie1_gnt_b", gnt_b, 0);
        check("tie1_wr", mem_wr, 1);
        check("tie1_addr", mem_address, 4'h1);
        check("tie1_data", mem_write_data, 16'h1111);
        cycle();
        drive_a(1'b0, 1'b0, 4'h0, 16'h0);
        #1;
        check("tie2_gnt_b", gnt_b, 1);
        check("tie2_gnt_a", gnt_a, 0);
        check("tie2_addr", mem_address, 4'h2);
        check("tie2_data", mem_write_data, 16'h2222);
        cycle();
        drive_b(1'b0, 1'b0, 4'h0, 16'h0);

        // A writes BEEF then reads it back on the next cycle
        drive_a(1'b1, 1'b1, 4'hC, 16'hBEEF);
        #1;
        check("w_gnt_a", gnt_a, 1);
        check("w_wr", mem_wr, 1);
        check("w_addr", mem_address, 4'hC);
        cycle();
        wr_a = 1'b0;
        #1;
        check("r_gnt_a", gnt_a, 1);
        check("r_wr", mem_wr, 0);
        check("r_addr", mem_address, 4'hC);
        cycle();
        drive_a(1'b0, 1'b0, 4'h0, 16'h0);
        #1;
        check("idle_wr", mem_wr, 0);
        check("idle_addr", mem_address, 0);
        check("idle_data", mem_write_data, 0);
        check("idle_gnt", {gnt_a, gnt_b}, 0);
        check("lat1_rvalid_a", rvalid_a, 0);
        cycle();
        #1;
        check("lat2_rvalid_a", rvalid_a, 0);
        cycle();
        #1;
        check("lat3_rvalid_a", rvalid_a, 1);
        check("lat3_rvalid_b", rvalid_b, 0);
        check("lat3_rdata_a", rdata_a, 16'hBEEF);
        cycle();

        // sustained contention: last grant was A, so B,A,B,A,B,A
        drive_a(1'b1, 1'b0, 4'h1, 16'h0);
        drive_b(1'b1, 1'b0, 4'h2, 16'h0);
        for (int c = 0; c < 9; c++) begin
            if (c == 6) begin
                req_a = 1'b0;
                req_b = 1'b0;
            end
            #1;
            exp_gb = (c < 6) && (c % 2 == 0);
            exp_ga = (c < 6) && (c % 2 == 1);
            exp_vb = (c >= 3) && ((c - 3) % 2 == 0);
            exp_va = (c >= 3) && ((c - 3) % 2 == 1);
            check("rr_gnt_a", gnt_a, exp_ga);
            check("rr_gnt_b", gnt_b, exp_gb);
            check("rr_rvalid_a", rvalid_a, exp_va);
            check("rr_rvalid_b", rvalid_b, exp_vb);
            if (exp_va) check("rr_rdata_a", rdata_a, 16'h1111);
            if (exp_vb) check("rr_rdata_b", rdata_b, 16'h2222);
            cycle();
        end

        // three back-to-back reads from A come back on three consecutive cycles, in order
        rd_addr[0] = 4'h1; rd_addr[1] = 4'h2; rd_addr[2] = 4'hC;
        exp_rd[0] = 16'h1111; exp_rd[1] = 16'h2222; exp_rd[2] = 16'hBEEF;
        for (int c = 0; c < 6; c++) begin
            if (c < 3) drive_a(1'b1, 1'b0, rd_addr[c], 16'h0);
            else       drive_a(1'b0, 1'b0, 4'h0, 16'h0);
            #1;
            check("b2b_gnt_a", gnt_a, (c < 3) ? 1 : 0);
            if (c < 3) check("b2b_addr", mem_address, rd_addr[c]);
            check("b2b_rvalid_a", rvalid_a, (c >= 3) ? 1 : 0);
            if (c >= 3) check("b2b_rdata_a", rdata_a, exp_rd[c-3]);
            cycle();
        end

        // reset with two reads in flight: no rvalid, clear restarts at 0
        drive_a(1'b1, 1'b0, 4'h1, 16'h0);
        cycle();
        cycle();
        drive_a(1'b0, 1'b0, 4'h0, 16'h0);
        #1;
        rst_n = 1'b0;
        #1;
        check("mid_rst_rvalid_a", rvalid_a, 0);
        check("mid_rst_ready", ready, 0);
        check("mid_rst_state", state_dbg, 0);
        check("mid_rst_addr", mem_address, 0);
        cycle();
        rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            #1;
            check("reclr_rvalid_a", rvalid_a, 0);
            check("reclr_rvalid_b", rvalid_b, 0);
            check("reclr_wr", mem_wr, 1);
            check("reclr_addr", mem_address, c);
            cycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
